// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with single-cycle logic/arith ops and iterative mul/div/rem
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [0:0] {S_IDLE, S_ITER} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_q;
    // acc_q: product accumulator (MUL) or partial remainder (DIVU/REMU)
    // opa_q: shifting multiplicand (MUL) or dividend/quotient register (DIVU/REMU)
    // opb_q: shifting multiplier (MUL) or divisor (DIVU/REMU)
    logic [WIDTH-1:0] acc_q, opa_q, opb_q;

    logic             is_iter;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf, sc_ill;

    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_d, div_quo_d;
    logic [WIDTH-1:0] iter_result;

    assign ready_o = (state_q == S_IDLE);
    assign is_iter = (ctrl_i == OP_MUL) || (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);
    assign sum     = src1_i + src2_i;
    assign diff    = src1_i - src2_i;

    // Single-cycle result, overflow and illegal-opcode decode from the live operands
    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        sc_ill    = 1'b0;
        case (ctrl_i)
            OP_AND: sc_result = src1_i & src2_i;
            OP_OR:  sc_result = src1_i | src2_i;
            OP_NOR: sc_result = ~(src1_i | src2_i);
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                            (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                            (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_MUL, OP_DIVU, OP_REMU: sc_ill = 1'b0;
            default: sc_ill = 1'b1;
        endcase
    end

    // One shift/add (MUL) or restoring shift/subtract (DIVU/REMU) step
    always_comb begin
        mul_acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;
        div_shift = {acc_q, opa_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // When div_ge holds the true difference is below the divisor, so WIDTH bits suffice
        div_rem_d = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
        div_quo_d = {opa_q[WIDTH-2:0], div_ge};
        case (op_q)
            OP_MUL:  iter_result = mul_acc_d;
            OP_DIVU: iter_result = div_quo_d;
            default: iter_result = div_rem_d;
        endcase
    end

    // Next-state: IDLE moves to ITER on an accepted iterative op, ITER returns after the last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (valid_i && is_iter) state_d = S_ITER;
            S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath: operand capture, iteration registers and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            valid_o    <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b1;
            overflow_o <= 1'b0;
            illegal_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (state_q == S_IDLE) begin
                if (valid_i) begin
                    if (is_iter) begin
                        // MUL and DIV share the same load: acc cleared, A and B captured
                        op_q  <= ctrl_i;
                        cnt_q <= CNT_W'(WIDTH);
                        acc_q <= '0;
                        opa_q <= src1_i;
                        opb_q <= src2_i;
                    end else begin
                        valid_o    <= 1'b1;
                        result_o   <= sc_result;
                        zero_o     <= (sc_result == '0);
                        overflow_o <= sc_ovf;
                        illegal_o  <= sc_ill;
                    end
                end
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_q <= mul_acc_d;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                end else begin
                    acc_q <= div_rem_d;
                    opa_q <= div_quo_d;
                end
                if (cnt_q == CNT_W'(1)) begin
                    valid_o    <= 1'b1;
                    result_o   <= iter_result;
                    zero_o     <= (iter_result == '0);
                    overflow_o <= 1'b0;
                    illegal_o  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;
    localparam int W = 32;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_MUL  = 4'b1000;
    localparam logic [3:0] C_DIVU = 4'b1001;
    localparam logic [3:0] C_REMU = 4'b1010;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic [3:0]   ctrl = '0;
    logic         ready_o, valid_o, zero_o, overflow_o, illegal_o;
    logic [W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         il;
    } vec_t;

    vec_t vecs[13];

    alu_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .src1_i(src1), .src2_i(src2), .ctrl_i(ctrl), .valid_o(valid_o),
        .result_o(result_o), .zero_o(zero_o), .overflow_o(overflow_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_iter(input string name, input logic [3:0] c, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp, input bit inject);
        int lows;
        int vlds;
        ctrl = c; src1 = a; src2 = b; valid_i = 1'b1;
        step();
        valid_i = 1'b0; ctrl = C_AND; src1 = '0; src2 = '0;
        lows = 0;
        vlds = 0;
        for (int k = 1; k <= W; k++) begin
            if (!ready_o) lows++;
            if (valid_o) vlds++;
            if (inject && k == 5) begin
                ctrl = C_ADD; src1 = 1; src2 = 1; valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            step();
        end
        chk({name, " ready low cycles"}, W'(lows), W'(W));
        chk({name, " early valid"}, W'(vlds), '0);
        chk1({name, " valid at N+W+1"}, valid_o, 1'b1);
        chk1({name, " ready at N+W+1"}, ready_o, 1'b1);
        chk({name, " result"}, result_o, exp);
        chk1({name, " zero"}, zero_o, (exp == '0));
        chk1({name, " overflow"}, overflow_o, 1'b0);
        chk1({name, " illegal"}, illegal_o, 1'b0);
        step();
        chk1({name, " no extra valid"}, valid_o, 1'b0);
    endtask

    initial begin
        int vcount;

        vecs[0]  = '{C_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{C_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{C_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{C_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{C_SLT, 32'h00000003, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b1111, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{C_OR,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{C_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{C_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{C_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{C_SLT, 32'hFFFFFFFF, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{C_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b0011, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        step();
        step();
        chk1("reset valid", valid_o, 1'b0);
        chk1("reset ready", ready_o, 1'b1);
        chk("reset result", result_o, '0);
        chk1("reset zero", zero_o, 1'b1);
        chk1("reset overflow", overflow_o, 1'b0);
        chk1("reset illegal", illegal_o, 1'b0);
        rst = 1'b0;
        step();

        // Back-to-back single-cycle ops: valid_i held high the whole table
        for (int i = 0; i < 13; i++) begin
            ctrl = vecs[i].ctrl; src1 = vecs[i].a; src2 = vecs[i].b; valid_i = 1'b1;
            step();
            chk1($sformatf("vec%0d valid", i), valid_o, 1'b1);
            chk1($sformatf("vec%0d ready", i), ready_o, 1'b1);
            chk($sformatf("vec%0d result", i), result_o, vecs[i].res);
            chk1($sformatf("vec%0d zero", i), zero_o, vecs[i].z);
            chk1($sformatf("vec%0d overflow", i), overflow_o, vecs[i].ov);
            chk1($sformatf("vec%0d illegal", i), illegal_o, vecs[i].il);
        end
        valid_i = 1'b0;
        step();
        chk1("valid drops after table", valid_o, 1'b0);

        run_iter("mul", C_MUL, 32'h00010001, 32'h00010001, 32'h00020001, 1'b1);
        run_iter("divu 100/7", C_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        run_iter("remu 100/7", C_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
        run_iter("divu by 0", C_DIVU, 32'h00001234, 32'h0, 32'hFFFFFFFF, 1'b0);
        run_iter("mul ones", C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_iter("remu ff/16", C_REMU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 1'b0);
        run_iter("remu by 0", C_REMU, 32'h00001234, 32'h0, 32'h00001234, 1'b0);

        // Reset mid-ITER: MUL aborted, no valid_o for it
        ctrl = C_MUL; src1 = 32'd3; src2 = 32'd5; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("abort ready", ready_o, 1'b1);
        chk("abort result", result_o, '0);
        chk1("abort zero", zero_o, 1'b1);
        chk1("abort valid", valid_o, 1'b0);
        vcount = 0;
        for (int k = 0; k < W + 5; k++) begin
            if (valid_o) vcount++;
            step();
        end
        chk("abort no late valid", W'(vcount), '0);
        ctrl = C_ADD; src1 = 32'd2; src2 = 32'd3; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk1("post-abort add valid", valid_o, 1'b1);
        chk("post-abort add result", result_o, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
